i2s_tdm_master: RTL and testbench

Parametrised successor to the fixed stereo I2S output stage. It serialises one frame of CHANNELS samples per frame period onto i2s_ck/i2s_ws/i2s_sd. Supported framings are I2S, left-justified, and DSP/TDM pulse mode. Sits after trans_buffer in the out_clk domain and takes whole frames through a one-entry valid/ready holding register. Adds what the previous generation lacked: configurable width, channel count and bit-clock divider, plus underrun and frame-start reporting.

---
 rtl/i2s_tdm_master.sv | 148 ++++++++++++++
 tb/tb_i2s_tdm_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_master.sv
// Frame serialiser for I2S, left-justified and DSP/TDM pulse framing, fed whole
// frames through a one-entry holding register; reports frame loads and underruns.
//
// state | meaning
// IDLE  | ck/ws/sd parked low, divider and bit counter cleared
// RUN   | bit clock running, frames shifted out back to back
module i2s_tdm_master #(
    parameter int CHANNELS    = 2,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 32,
    parameter int CK_DIV      = 1,
    parameter int MODE        = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANNELS*SAMPLE_BITS-1:0] in_data,
    output logic                            i2s_ck,
    output logic                            i2s_ws,
    output logic                            i2s_sd,
    output logic                            frame_start,
    output logic                            underrun
);
    localparam int F  = CHANNELS * SLOT_BITS;
    localparam int BW = (F > 1) ? $clog2(F) : 1;
    localparam int DW = (CK_DIV > 1) ? $clog2(CK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(F - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(F / 2);
    localparam logic [DW-1:0] DIV_LAST = DW'(CK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                          state_q, state_d;
    logic [DW-1:0]                   div_q, div_d;
    logic [BW-1:0]                   bit_q, bit_d;
    logic                            ck_q, ck_d;
    logic                            ws_q, ws_d;
    logic [F-1:0]                    shift_q, shift_d;
    logic [F-1:0]                    frame_img;
    logic                            hold_valid;
    logic [CHANNELS*SAMPLE_BITS-1:0] hold_data;
    logic                            div_tc;
    logic                            ck_fall;
    logic                            bit_wrap;
    logic                            load;

    // Word select for the bit currently on sd; MODE 0 leads the data by one bit.
    function automatic logic ws_at(input logic [BW-1:0] b);
        logic w;
        case (MODE)
            0:       w = (b == BIT_LAST) ? 1'b0 : (b >= BIT_HALF - BW'(1));
            1:       w = (b >= BIT_HALF);
            default: w = (b == BIT_LAST);
        endcase
        return w;
    endfunction

    // Frame image with frame bit 0 at the MSB; padding bits stay zero.
    always_comb begin
        frame_img = '0;
        if (hold_valid) begin
            for (int n = 0; n < CHANNELS; n++) begin
                frame_img[F-1-n*SLOT_BITS -: SAMPLE_BITS] = hold_data[n*SAMPLE_BITS +: SAMPLE_BITS];
            end
        end
    end

    assign div_tc   = (div_q == DIV_LAST);
    assign ck_fall  = (state_q == RUN) && div_tc && ck_q;
    assign bit_wrap = (bit_q == BIT_LAST);
    assign load     = !rst && en && ((state_q == IDLE) || (ck_fall && bit_wrap));
    assign in_ready = !hold_valid && !load;

    assign i2s_ck = ck_q;
    assign i2s_ws = ws_q;
    assign i2s_sd = shift_q[F-1];

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        ck_d    = ck_q;
        ws_d    = ws_q;
        shift_d = shift_q;
        if (!en) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            ck_d    = 1'b0;
            ws_d    = 1'b0;
            shift_d = '0;
        end else if (state_q == IDLE) begin
            state_d = RUN;
            div_d   = '0;
            bit_d   = '0;
            ck_d    = 1'b0;
            ws_d    = ws_at('0);
            shift_d = frame_img;
        end else if (div_tc) begin
            div_d = '0;
            ck_d  = !ck_q;
            if (ck_q) begin
                if (bit_wrap) begin
                    bit_d   = '0;
                    shift_d = frame_img;
                end else begin
                    bit_d   = bit_q + BW'(1);
                    shift_d = {shift_q[F-2:0], 1'b0};
                end
                ws_d = ws_at(bit_d);
            end
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            ck_q        <= 1'b0;
            ws_q        <= 1'b0;
            shift_q     <= '0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            ck_q        <= ck_d;
            ws_q        <= ws_d;
            shift_q     <= shift_d;
            frame_start <= load;
            underrun    <= load && !hold_valid;
            if (load) begin
                hold_valid <= 1'b0;
            end else if (in_valid && in_ready) begin
                hold_valid <= 1'b1;
                hold_data  <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tdm_master.sv
// Three differently configured serialisers driven with random frames and compared
// every clock against a timing model derived from elapsed cycles since start.
module tb_i2s_tdm_master;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cfg_ch   [N] = '{2, 8, 2};
    int cfg_sb   [N] = '{24, 32, 16};
    int cfg_div  [N] = '{2, 1, 3};
    int cfg_mode [N] = '{0, 2, 1};

    logic         en  [N];
    logic         iv  [N];
    logic [255:0] dat [N];
    logic o_rdy [N];
    logic o_ck  [N];
    logic o_ws  [N];
    logic o_sd  [N];
    logic o_fs  [N];
    logic o_ur  [N];

    i2s_tdm_master #(.CHANNELS(2), .SLOT_BITS(32), .SAMPLE_BITS(24), .CK_DIV(2), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .en(en[0]), .in_valid(iv[0]), .in_ready(o_rdy[0]),
        .in_data(dat[0][47:0]), .i2s_ck(o_ck[0]), .i2s_ws(o_ws[0]), .i2s_sd(o_sd[0]),
        .frame_start(o_fs[0]), .underrun(o_ur[0]));
    i2s_tdm_master #(.CHANNELS(8), .SLOT_BITS(32), .SAMPLE_BITS(32), .CK_DIV(1), .MODE(2)) u_b (
        .clk(clk), .rst(rst), .en(en[1]), .in_valid(iv[1]), .in_ready(o_rdy[1]),
        .in_data(dat[1]), .i2s_ck(o_ck[1]), .i2s_ws(o_ws[1]), .i2s_sd(o_sd[1]),
        .frame_start(o_fs[1]), .underrun(o_ur[1]));
    i2s_tdm_master #(.CHANNELS(2), .SLOT_BITS(32), .SAMPLE_BITS(16), .CK_DIV(3), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .en(en[2]), .in_valid(iv[2]), .in_ready(o_rdy[2]),
        .in_data(dat[2][31:0]), .i2s_ck(o_ck[2]), .i2s_ws(o_ws[2]), .i2s_sd(o_sd[2]),
        .frame_start(o_fs[2]), .underrun(o_ur[2]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: elapsed cycles since RUN entry plus held/current frame.
    bit           m_run  [N];
    int           m_t    [N];
    bit           m_held [N];
    logic [255:0] m_hd   [N];
    logic [255:0] m_cur  [N];
    bit           m_fs   [N];
    bit           m_ur   [N];
    bit           acc_now[N];
    int           cyc = 0;
    bit           gap_on = 0;
    int           last_fs = -1;

    function automatic int frame_bits(int d); return cfg_ch[d] * 32; endfunction
    function automatic int period(int d); return frame_bits(d) * 2 * cfg_div[d]; endfunction
    function automatic int cur_bit(int d); return (m_t[d] / (2 * cfg_div[d])) % frame_bits(d); endfunction

    function automatic bit load_next(int d);
        return en[d] && (!m_run[d] || ((m_t[d] + 1) % period(d) == 0));
    endfunction

    function automatic bit exp_ws(int d);
        int f = frame_bits(d);
        int b = cur_bit(d);
        if (!m_run[d]) return 1'b0;
        case (cfg_mode[d])
            0:       return ((b + 1) % f) >= f / 2;
            1:       return b >= f / 2;
            default: return b == f - 1;
        endcase
    endfunction

    function automatic bit exp_sd(int d);
        int b    = cur_bit(d);
        int sb   = cfg_sb[d];
        int slot = b / 32;
        int pos  = b % 32;
        if (!m_run[d] || pos >= sb) return 1'b0;
        return m_cur[d][slot * sb + sb - 1 - pos];
    endfunction

    task automatic model_edge(int d);
        bit ld  = load_next(d);
        bit acc = iv[d] && !m_held[d] && !ld;
        m_fs[d] = 0;
        m_ur[d] = 0;
        if (!en[d]) m_run[d] = 0;
        else if (!m_run[d]) begin m_run[d] = 1; m_t[d] = 0; end
        else m_t[d]++;
        if (ld) begin
            m_fs[d]  = 1;
            m_ur[d]  = !m_held[d];
            m_cur[d] = m_held[d] ? m_hd[d] : '0;
            m_held[d] = 0;
        end
        if (acc) begin
            m_held[d] = 1;
            m_hd[d]   = dat[d];
        end
        acc_now[d] = acc;
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < N; d++)
            chk($sformatf("rdy%0d", d), o_rdy[d], !m_held[d] && !load_next(d));
        @(posedge clk);
        for (int d = 0; d < N; d++) model_edge(d);
        cyc++;
        #1;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("ck%0d", d), o_ck[d], m_run[d] && ((m_t[d] % (2 * cfg_div[d])) >= cfg_div[d]));
            chk($sformatf("ws%0d", d), o_ws[d], exp_ws(d));
            chk($sformatf("sd%0d", d), o_sd[d], exp_sd(d));
            chk($sformatf("fs%0d", d), o_fs[d], m_fs[d]);
            chk($sformatf("ur%0d", d), o_ur[d], m_ur[d]);
        end
        if (gap_on && o_fs[0] === 1'b1) begin
            if (last_fs >= 0) chk("fs_gap0", cyc - last_fs, 256);
            last_fs = cyc;
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_idle_outputs(string pfx);
        for (int d = 0; d < N; d++) begin
            chk($sformatf("%s_ck%0d", pfx, d), o_ck[d], 1'b0);
            chk($sformatf("%s_ws%0d", pfx, d), o_ws[d], 1'b0);
            chk($sformatf("%s_sd%0d", pfx, d), o_sd[d], 1'b0);
            chk($sformatf("%s_fs%0d", pfx, d), o_fs[d], 1'b0);
            chk($sformatf("%s_ur%0d", pfx, d), o_ur[d], 1'b0);
            chk($sformatf("%s_rdy%0d", pfx, d), o_rdy[d], 1'b1);
        end
    endtask

    int        offer_at [N];
    logic [31:0] pc     [N];
    bit        dropped  [N];
    int        low_cnt  [N];

    initial begin
        for (int d = 0; d < N; d++) begin
            en[d] = 0; iv[d] = 0; dat[d] = '0;
            m_run[d] = 0; m_t[d] = 0; m_held[d] = 0; m_hd[d] = '0; m_cur[d] = '0;
            m_fs[d] = 0; m_ur[d] = 0; acc_now[d] = 0;
        end
        #12;
        check_idle_outputs("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Preloaded frames, then continuous running.
        dat[0] = {208'd0, 24'h123456, 24'hABCDEF};
        dat[1] = rnd256();
        dat[2] = rnd256();
        for (int d = 0; d < N; d++) iv[d] = 1;
        tick();
        for (int d = 0; d < N; d++) begin iv[d] = 0; en[d] = 1; end
        repeat (1200) tick();

        // Starved: underruns, then one late frame each.
        gap_on = 1;
        last_fs = -1;
        for (int d = 0; d < N; d++) offer_at[d] = 600 + $urandom_range(0, 300);
        for (int i = 0; i < 1800; i++) begin
            tick();
            for (int d = 0; d < N; d++) begin
                if (i == offer_at[d]) begin iv[d] = 1; dat[d] = rnd256(); end
                else if (acc_now[d]) iv[d] = 0;
            end
        end
        gap_on = 0;

        // Back-to-back offers with an incrementing pattern.
        for (int d = 0; d < N; d++) begin
            pc[d] = $urandom;
            dat[d] = {8{pc[d]}};
            iv[d] = 1;
        end
        repeat (3000) begin
            tick();
            for (int d = 0; d < N; d++) if (acc_now[d]) begin
                pc[d]  = pc[d] + 32'd1;
                dat[d] = {8{pc[d] ^ (pc[d] << 7)}};
            end
        end

        // Enable dropped at bit 40 for ten cycles.
        for (int d = 0; d < N; d++) begin iv[d] = 0; dropped[d] = 0; low_cnt[d] = 0; end
        repeat (2500) begin
            tick();
            for (int d = 0; d < N; d++) begin
                if (!dropped[d] && m_run[d] && cur_bit(d) == 40 && (m_t[d] % (2 * cfg_div[d])) == 0) begin
                    en[d] = 0; dropped[d] = 1; low_cnt[d] = 10;
                end else if (low_cnt[d] > 0) begin
                    low_cnt[d]--;
                    if (low_cnt[d] == 0) en[d] = 1;
                end
            end
        end
        for (int d = 0; d < N; d++) chk($sformatf("dropped%0d", d), dropped[d], 1'b1);

        // Asynchronous reset mid-frame with a frame held.
        for (int d = 0; d < N; d++) begin iv[d] = 1; dat[d] = rnd256(); end
        tick();
        for (int d = 0; d < N; d++) iv[d] = 0;
        repeat (100) tick();
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("arst");
        for (int d = 0; d < N; d++) begin
            m_run[d] = 0; m_t[d] = 0; m_held[d] = 0; m_fs[d] = 0; m_ur[d] = 0; acc_now[d] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (900) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
